// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the 7-segment scan controller.
//   seg_t      : active-low segment vector, bit order [0:6] = a..g
//   SEG_BLANK  : all segments off
//   DIGIT_W    : bits per displayed digit
//   GLYPH_TAB  : hex glyphs 0..F, active-low a..g
// -----------------------------------------------------------------------------
package disp_pkg;

  typedef logic [0:6] seg_t;

  localparam int   DIGIT_W   = 4;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPH_TAB [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg_glyph_dec.sv
// -----------------------------------------------------------------------------
// seg_glyph_dec
// Combinational 4-bit hex digit to active-low 7-segment glyph decoder.
// Ports:
//   digit_i : hex digit 0..F
//   seg_o   : active-low segments, [0:6] = a..g
// -----------------------------------------------------------------------------
module seg_glyph_dec
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output seg_t               seg_o
);

  assign seg_o = GLYPH_TAB[digit_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One digit is lit per slot of REFRESH_DIV clocks. New words are
// held in a pending buffer and committed to the display buffer only at the
// frame wrap, so a frame never mixes old and new digits.
//
// Optional feature macro: DISP_BLINK_EN (adds the blink port and the
// frame-counted blank phase).
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   value      : NUM_DIGITS hex digits, digit i = value[4i+3:4i]
//   load       : 1-cycle strobe, capture value into the pending buffer
//   dig_en     : per-digit enable, 0 leaves that slot blank
//   blink      : blink request (DISP_BLINK_EN only)
//   an         : anode selects, active-low, an[i] drives digit i
//   SSeg       : segments, active-low, [0:6] = a..g
//   pending    : pending buffer holds an uncommitted word
//   frame_done : 1-cycle pulse at each frame wrap
// -----------------------------------------------------------------------------
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dig_en,
`ifdef DISP_BLINK_EN
  input  logic                          blink,
`endif
  output logic [NUM_DIGITS-1:0]         an,
  output seg_t                          SSeg,
  output logic                          pending,
  output logic                          frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = DIGIT_W * NUM_DIGITS;

  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         disp_buf_q, disp_buf_d;
  logic [VW-1:0]         pend_buf_q, pend_buf_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;

  logic                  tick, wrap, blank_slot, blink_blank;
  logic [DIGIT_W-1:0]    digit;
  seg_t                  glyph;

  assign tick = (presc_q == PW'(REFRESH_DIV - 1));
  assign idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  assign wrap = tick && (idx_d == '0);

`ifdef DISP_BLINK_EN
  logic [BW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blank_phase_q, blank_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blank_phase_d = blank_phase_q;
    if (!blink) begin
      frame_cnt_d   = '0;
      blank_phase_d = 1'b0;
    end else if (wrap) begin
      if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blank_phase_d = ~blank_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Use the post-wrap phase so the first slot of a blank frame is already dark.
  assign blink_blank = blink && blank_phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      blank_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blank_phase_q <= blank_phase_d;
    end
  end
`else
  assign blink_blank = 1'b0;
`endif

  // Buffer update: a load coinciding with the wrap bypasses the pending buffer.
  always_comb begin
    disp_buf_d = disp_buf_q;
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    if (load) begin
      pend_buf_d = value;
      pending_d  = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        disp_buf_d = value;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_buf_d = pend_buf_q;
        pending_d  = 1'b0;
      end
    end
  end

  // Decode from the next display buffer so digit 0 of a wrap slot shows the
  // word committed on that same edge.
  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) digit = disp_buf_d[i*DIGIT_W +: DIGIT_W];
    end
  end

  seg_glyph_dec u_dec (
    .digit_i (digit),
    .seg_o   (glyph)
  );

  assign blank_slot = !dig_en[idx_d] || blink_blank;

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (!blank_slot) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= IW'(NUM_DIGITS - 1);
      disp_buf_q   <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      disp_buf_q   <= disp_buf_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      frame_done_q <= wrap;
      if (tick) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
      end
    end
  end

  assign an         = an_q;
  assign SSeg       = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dig_en;
  logic        blink;
  logic [3:0]  an;
  logic [0:6]  SSeg;
  logic        pending;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [0:6] G0 = 7'b0000001;
  localparam logic [0:6] G1 = 7'b1001111;
  localparam logic [0:6] G2 = 7'b0010010;
  localparam logic [0:6] G8 = 7'b0000000;
  localparam logic [0:6] GA = 7'b0001000;
  localparam logic [0:6] GC = 7'b0110001;
  localparam logic [0:6] GF = 7'b0111000;
  localparam logic [0:6] BL = 7'b1111111;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dig_en     (dig_en),
`ifdef DISP_BLINK_EN
    .blink      (blink),
`endif
    .an         (an),
    .SSeg       (SSeg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  // cyc counts edges since rst was released; edge 4 is the first tick.
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    step(2);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    value  = 16'h0000;
    dig_en = 4'b1111;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step_to(c);
      n_tests++;
      if (an !== 4'b1111 || SSeg !== BL || frame_done !== 1'b0 || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_blank c%0d: an=%b SSeg=%b fd=%b pend=%b want 1111 1111111 0 0",
                 c, an, SSeg, frame_done, pending);
      end
    end
    step_to(4);
    n_tests++;
    if (an !== 4'b1110 || SSeg !== G0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_tick: an=%b SSeg=%b fd=%b want 1110 0000001 1", an, SSeg, frame_done);
    end
    step_to(5);
    n_tests++;
    if (frame_done !== 1'b0 || an !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_fd_pulse: fd=%b an=%b want 0 1110", frame_done, an);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [0:6] exp_seg [4] = '{GF, GA, G2, G1};
    value  = 16'h0000;
    dig_en = 4'b1111;
    do_reset();
    step(1);
    value = 16'h12AF;
    load  = 1'b1;
    step(1);
    load = 1'b0;
    n_tests++;
    if (pending !== 1'b1 || an !== 4'b1111) begin
      n_fail++;
      $display("FAIL load_pending: pend=%b an=%b want 1 1111", pending, an);
    end
    for (int s = 0; s < 4; s++) begin
      step_to(4 + 4 * s);
      n_tests++;
      if (an !== exp_an[s] || SSeg !== exp_seg[s] || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL load_scan slot%0d: an=%b SSeg=%b pend=%b want %b %b 0",
                 s, an, SSeg, pending, exp_an[s], exp_seg[s]);
      end
    end
    step_to(19);
    n_tests++;
    if (an !== 4'b0111 || SSeg !== G1) begin
      n_fail++;
      $display("FAIL load_hold: an=%b SSeg=%b want 0111 1001111", an, SSeg);
    end
    step_to(20);
    n_tests++;
    if (an !== 4'b1110 || SSeg !== GF || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL load_second_frame: an=%b SSeg=%b fd=%b want 1110 0111000 1", an, SSeg, frame_done);
    end
  endtask

  // Continues from test_load_commit: cyc 20 is digit 0 of the second frame.
  task automatic test_mid_frame_load();
    step_to(24);
    value = 16'h0000;
    load  = 1'b1;
    step(1);
    load = 1'b0;
    n_tests++;
    if (pending !== 1'b1 || an !== 4'b1101 || SSeg !== GA) begin
      n_fail++;
      $display("FAIL mid_pending: pend=%b an=%b SSeg=%b want 1 1101 0001000", pending, an, SSeg);
    end
    step_to(28);
    n_tests++;
    if (an !== 4'b1011 || SSeg !== G2) begin
      n_fail++;
      $display("FAIL mid_old_d2: an=%b SSeg=%b want 1011 0010010", an, SSeg);
    end
    step_to(32);
    n_tests++;
    if (an !== 4'b0111 || SSeg !== G1 || pending !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_old_d3: an=%b SSeg=%b pend=%b want 0111 1001111 1", an, SSeg, pending);
    end
    step_to(36);
    n_tests++;
    if (an !== 4'b1110 || SSeg !== G0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_commit: an=%b SSeg=%b pend=%b want 1110 0000001 0", an, SSeg, pending);
    end
    step_to(40);
    n_tests++;
    if (an !== 4'b1101 || SSeg !== G0) begin
      n_fail++;
      $display("FAIL mid_new_d1: an=%b SSeg=%b want 1101 0000001", an, SSeg);
    end
  endtask

  task automatic test_dig_en();
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
    logic [0:6] exp_seg [4] = '{G8, BL, G8, BL};
    value  = 16'h0000;
    dig_en = 4'b0101;
    do_reset();
    value = 16'h8888;
    load  = 1'b1;
    step(1);
    load = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step_to(4 + 4 * s);
      n_tests++;
      if (an !== exp_an[s] || SSeg !== exp_seg[s]) begin
        n_fail++;
        $display("FAIL dig_en slot%0d: an=%b SSeg=%b want %b %b", s, an, SSeg, exp_an[s], exp_seg[s]);
      end
    end
    step_to(20);
    n_tests++;
    if (frame_done !== 1'b1 || an !== 4'b1110) begin
      n_fail++;
      $display("FAIL dig_en_wrap: fd=%b an=%b want 1 1110", frame_done, an);
    end
    dig_en = 4'b1111;
  endtask

  task automatic test_bypass_load();
    value  = 16'h0000;
    dig_en = 4'b1111;
    do_reset();
    step_to(3);
    value = 16'h00C0;
    load  = 1'b1;
    step(1);
    load = 1'b0;
    n_tests++;
    if (an !== 4'b1110 || SSeg !== G0 || pending !== 1'b0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_wrap: an=%b SSeg=%b pend=%b fd=%b want 1110 0000001 0 1",
               an, SSeg, pending, frame_done);
    end
    step_to(5);
    n_tests++;
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_pend: pend=%b want 0", pending);
    end
    step_to(8);
    n_tests++;
    if (an !== 4'b1101 || SSeg !== GC) begin
      n_fail++;
      $display("FAIL bypass_d1: an=%b SSeg=%b want 1101 0110001", an, SSeg);
    end
  endtask

  // Continues from test_bypass_load: cyc 12 is digit 2 of the first frame.
  task automatic test_reset_mid_frame();
    step_to(12);
    value = 16'h5555;
    load  = 1'b1;
    step(1);
    load = 1'b0;
    n_tests++;
    if (pending !== 1'b1 || an !== 4'b1011) begin
      n_fail++;
      $display("FAIL rstmid_pre: pend=%b an=%b want 1 1011", pending, an);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cyc = 0;
    n_tests++;
    if (an !== 4'b1111 || SSeg !== BL || pending !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_blank: an=%b SSeg=%b pend=%b fd=%b want 1111 1111111 0 0",
               an, SSeg, pending, frame_done);
    end
    step_to(3);
    n_tests++;
    if (an !== 4'b1111 || SSeg !== BL) begin
      n_fail++;
      $display("FAIL rstmid_c3: an=%b SSeg=%b want 1111 1111111", an, SSeg);
    end
    step_to(4);
    n_tests++;
    if (an !== 4'b1110 || SSeg !== G0 || frame_done !== 1'b1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_first: an=%b SSeg=%b fd=%b pend=%b want 1110 0000001 1 0",
               an, SSeg, frame_done, pending);
    end
    step_to(8);
    n_tests++;
    if (an !== 4'b1101 || SSeg !== G0) begin
      n_fail++;
      $display("FAIL rstmid_buf_cleared: an=%b SSeg=%b want 1101 0000001", an, SSeg);
    end
  endtask

  initial begin
    rst    = 1'b1;
    value  = 16'h0000;
    load   = 1'b0;
    dig_en = 4'b1111;
    blink  = 1'b0;
    test_reset();
    test_load_commit();
    test_mid_frame_load();
    test_dig_en();
    test_bypass_load();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Holds a NUM_DIGITS-digit hex/BCD word and cycles one digit at a time at a prescaled refresh rate. For the active digit it drives the anode and the decoded segment pattern. New words are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between the datapath producing the value and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 64, frames per blink half-period (used only with DISP_BLINK_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value  in  4*NUM_DIGITS  digit i = value[4i+3:4i]
load  in  1  1-cycle strobe: capture value into pending buffer
dig_en  in  NUM_DIGITS  per-digit enable; 0 = slot blank
blink  in  1  blink request (present only with DISP_BLINK_EN)
an  out  NUM_DIGITS  anode selects, active-low; an[i] drives digit i
SSeg  out  7  segments, active-low, bit order [0:6] = a..g
pending  out  1  pending buffer holds an uncommitted word
frame_done  out  1  1-cycle pulse at each frame wrap

Behaviour:
- Reset (sync, rst=1 at a clk edge) takes effect at that edge:
  - an = all 1s, SSeg = 7'b1111111, pending = 0, frame_done = 0.
  - prescaler = 0, idx = NUM_DIGITS-1, display and pending buffers = 0.
  - Reset mid-frame aborts the scan immediately; outputs blank on the next cycle.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
  - The first tick occurs REFRESH_DIV cycles after rst is released.
- On tick:
  - idx_next = (idx == NUM_DIGITS-1) ? 0 : idx+1; idx <= idx_next.
  - an and SSeg are registered for digit idx_next on the same edge, so they change exactly at the tick edge.
  - an = ~(1 << idx_next) when dig_en[idx_next] = 1; otherwise an = all 1s and SSeg = 7'b1111111. The slot is still consumed.
- Frame wrap: a tick with idx_next == 0.
  - frame_done pulses on that edge.
  - If pending = 1, the display buffer takes the pending word and pending clears.
  - Digit 0 of that same slot shows the newly committed word.
- load: pending buffer <= value and pending <= 1 on any cycle. Back-to-back loads overwrite; the last one before the wrap wins.
- load coincident with a wrap tick: the display buffer takes value directly (bypass) and pending stays 0.
- Glyphs (active-low, a..g):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
- No backpressure; load is always accepted.

Optional Feature:
DISP_BLINK_EN:
- Defined:
  - blink port exists, plus a frame counter 0..BLINK_FRAMES-1 that increments at each wrap and a blank_phase flag that toggles when the counter wraps.
  - While blink = 1 and blank_phase = 1, an = all 1s and SSeg = 7'b1111111 for all slots. Scanning, commit and frame_done continue unchanged.
  - blink = 0 forces blank_phase to 0 and clears the counter.
- Undefined: no blink port, counter or flag.

Decomposition:
- Package disp_pkg holds:
  - SEG_BLANK = 7'b1111111
  - DIGIT_W = 4
  - the 16-entry glyph constant table
- Sub-module seg_glyph_dec: combinational 4-bit to 7-bit active-low decoder using the package table; one instance, fed by display_buf[idx_next].
- Scan/prescaler/buffer logic stays in disp_scan_ctrl.

Test Plan:
All with NUM_DIGITS = 4, REFRESH_DIV = 4.
1. Reset release -> an = 1111, SSeg = 1111111 for cycles 1-3; at cycle 4 an = 1110 showing digit 0 of 16'h0000 (SSeg = 0000001), frame_done = 1.
2. load 16'h12AF one cycle after reset release -> pending = 1. At the first tick (wrap), pending = 0 and the scan gives an = 1110 / 0111000, 1101 / 0001000, 1011 / 0010010, 0111 / 1001111, one slot every 4 cycles.
3. load 16'h0000 while idx = 1 -> digits 2 and 3 still show 2 and 1. The next wrap commits, then all slots show 0000001.
4. dig_en = 4'b0101, value 16'h8888 -> slots 0 and 2 show 0000000; slots 1 and 3 give an = 1111 / SSeg = 1111111.
5. load 16'h00C0 asserted on the wrap-tick cycle -> digit 0 immediately shows 0000001, pending stays 0; digit 1 shows 0110001 next slot.
6. rst asserted for one cycle while idx = 2 -> next cycle an = 1111 and SSeg = 1111111; display buffer = 0; first lit slot is digit 0 after 4 cycles.
